// File: rtl/division.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one quotient bit per
// enabled clock, with sign fix-up, quotient saturation and divide-by-zero reporting.
module division #(
  parameter int WY = 21,
  parameter int WC = 10,
  parameter int WQ = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [WY-1:0] Y,
  input  logic [WC-1:0] C,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [WQ-1:0] Q,
  output logic [WC-1:0] R,
  output logic          dz,
  output logic          ovf,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CW = (WY > 1) ? $clog2(WY) : 1;
  localparam logic [WY-1:0] ONE_Y  = {{(WY-1){1'b0}}, 1'b1};
  localparam logic [WC-1:0] ONE_C  = {{(WC-1){1'b0}}, 1'b1};
  localparam logic [WY-1:0] QLIM   = ONE_Y << (WQ - 1);
  localparam logic [WY-1:0] QPOS   = QLIM - ONE_Y;
  localparam logic [WQ-1:0] QMAX_C = {1'b0, {(WQ-1){1'b1}}};
  localparam logic [WQ-1:0] QMIN_C = {1'b1, {(WQ-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r, state_nxt;
  logic [CW-1:0] cnt_r;
  logic [WY-1:0] ysh_r, qmag_r;
  logic [WC-1:0] cmag_r, rem_r;
  logic          qneg_r, rneg_r;

  logic          c_zero_s, last_s;
  logic [WY-1:0] ymag_s, qmag_nxt_s, qsgn_s;
  logic [WC-1:0] cmag_s, rem_nxt_s, r_fin_s;
  logic [WC:0]   trial_s, diff_s;
  logic [WQ-1:0] q_fin_s;
  logic          ovf_fin_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign c_zero_s  = (C == {WC{1'b0}});
  assign last_s    = (cnt_r == {CW{1'b0}});
  // Y magnitude needs no extra bit: -2^(WY-1) maps to unsigned 2^(WY-1).
  assign ymag_s    = Y[WY-1] ? (~Y + ONE_Y) : Y;
  assign cmag_s    = C[WC-1] ? (~C + ONE_C) : C;
  assign trial_s   = {rem_r, ysh_r[WY-1]};
  assign diff_s    = trial_s - {1'b0, cmag_r};

  // One restoring step: partial remainder shifted left with the next dividend bit.
  always_comb begin
    rem_nxt_s  = trial_s[WC-1:0];
    qmag_nxt_s = {qmag_r[WY-2:0], 1'b0};
    if (trial_s >= {1'b0, cmag_r}) begin
      rem_nxt_s  = diff_s[WC-1:0];
      qmag_nxt_s = {qmag_r[WY-2:0], 1'b1};
    end else begin
      rem_nxt_s  = trial_s[WC-1:0];
      qmag_nxt_s = {qmag_r[WY-2:0], 1'b0};
    end
  end

  // Sign application and saturation of the final step's result.
  always_comb begin
    qsgn_s    = qneg_r ? (~qmag_nxt_s + ONE_Y) : qmag_nxt_s;
    r_fin_s   = rneg_r ? (~rem_nxt_s + ONE_C) : rem_nxt_s;
    q_fin_s   = qsgn_s[WQ-1:0];
    ovf_fin_s = 1'b0;
    if (!qneg_r && (qmag_nxt_s > QPOS)) begin
      q_fin_s   = QMAX_C;
      ovf_fin_s = 1'b1;
    end else if (qneg_r && (qmag_nxt_s > QLIM)) begin
      q_fin_s   = QMIN_C;
      ovf_fin_s = 1'b1;
    end else begin
      q_fin_s   = qsgn_s[WQ-1:0];
      ovf_fin_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt = c_zero_s ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (ce) begin
      state_r <= state_nxt;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      ysh_r  <= {WY{1'b0}};
      qmag_r <= {WY{1'b0}};
      cmag_r <= {WC{1'b0}};
      rem_r  <= {WC{1'b0}};
      qneg_r <= 1'b0;
      rneg_r <= 1'b0;
      Q      <= {WQ{1'b0}};
      R      <= {WC{1'b0}};
      dz     <= 1'b0;
      ovf    <= 1'b0;
    end else if (ce) begin
      case (state_r)
        IDLE: begin
          if (in_valid && c_zero_s) begin
            Q   <= {WQ{1'b0}};
            R   <= {WC{1'b0}};
            dz  <= 1'b1;
            ovf <= 1'b0;
          end else if (in_valid) begin
            ysh_r  <= ymag_s;
            cmag_r <= cmag_s;
            rem_r  <= {WC{1'b0}};
            qmag_r <= {WY{1'b0}};
            qneg_r <= Y[WY-1] ^ C[WC-1];
            rneg_r <= Y[WY-1];
            cnt_r  <= CW'(WY - 1);
          end
        end
        CALC: begin
          ysh_r  <= {ysh_r[WY-2:0], 1'b0};
          rem_r  <= rem_nxt_s;
          qmag_r <= qmag_nxt_s;
          if (last_s) begin
            Q   <= q_fin_s;
            R   <= r_fin_s;
            dz  <= 1'b0;
            ovf <= ovf_fin_s;
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// Randomized bench for division: a reference model built from integer division and a
// handshake/latency scoreboard, compared against the DUT on every falling clock edge.
module tb_division;
  localparam int WY = 21;
  localparam int WC = 10;
  localparam int WQ = 11;
  localparam longint QMAXL = (longint'(1) << (WQ - 1)) - 1;
  localparam longint QMINL = -(longint'(1) << (WQ - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic signed [WY-1:0] Y = '0;
  logic signed [WC-1:0] C = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, dz, ovf, out_valid;
  logic signed [WQ-1:0] Q;
  logic signed [WC-1:0] R;

  int n_assert = 0;
  int n_fail = 0;

  bit m_busy = 1'b0;
  bit m_has = 1'b0;
  int m_left = 0;
  logic signed [WQ-1:0] e_q = '0;
  logic signed [WC-1:0] e_r = '0;
  logic e_dz = 1'b0;
  logic e_ovf = 1'b0;

  division #(.WY(WY), .WC(WC), .WQ(WQ)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .Y(Y), .C(C), .in_valid(in_valid),
    .in_ready(in_ready), .Q(Q), .R(R), .dz(dz), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Packed {q, r, dz, ovf} straight from signed integer division.
  function automatic logic [WQ+WC+1:0] ref_div(input longint y, input longint c);
    longint q, r;
    logic [WQ-1:0] qq;
    logic [WC-1:0] rr;
    logic ov;
    if (c == 0) return {{WQ{1'b0}}, {WC{1'b0}}, 1'b1, 1'b0};
    q = y / c;
    r = y % c;
    ov = 1'b0;
    if (q > QMAXL) begin q = QMAXL; ov = 1'b1; end
    else if (q < QMINL) begin q = QMINL; ov = 1'b1; end
    qq = q[WQ-1:0];
    rr = r[WC-1:0];
    return {qq, rr, 1'b0, ov};
  endfunction

  task automatic pin_model(input longint y, input longint c, input longint eq,
                           input longint er, input longint edz, input longint eov);
    logic [WQ+WC+1:0] res;
    logic signed [WQ-1:0] rq;
    logic signed [WC-1:0] rr;
    res = ref_div(y, c);
    rq = res[WQ+WC+1:WC+2];
    rr = res[WC+1:2];
    chk("model_q", longint'(rq), eq);
    chk("model_r", longint'(rr), er);
    chk("model_dz", longint'(res[1]), edz);
    chk("model_ovf", longint'(res[0]), eov);
  endtask

  // Scoreboard: result due WY enabled edges after accept (at once for a zero divisor).
  always @(posedge clk or negedge rst_n) begin
    logic [WQ+WC+1:0] res;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_has <= 1'b0;
      m_left <= 0;
    end else if (ce) begin
      if (m_has) begin
        if (out_ready) m_has <= 1'b0;
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_has <= 1'b1;
        end
      end else if (in_valid) begin
        res = ref_div(longint'(Y), longint'(C));
        e_q <= res[WQ+WC+1:WC+2];
        e_r <= res[WC+1:2];
        e_dz <= res[1];
        e_ovf <= res[0];
        if (C == '0) m_has <= 1'b1;
        else begin
          m_busy <= 1'b1;
          m_left <= WY;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", longint'(in_ready), longint'(!(m_busy || m_has)));
      chk("out_valid", longint'(out_valid), longint'(m_has));
      if (m_has) begin
        chk("q", longint'(Q), longint'(e_q));
        chk("r", longint'(R), longint'(e_r));
        chk("dz", longint'(dz), longint'(e_dz));
        chk("ovf", longint'(ovf), longint'(e_ovf));
      end
    end
  end

  task automatic run_pair(input longint y, input longint c, input bit tog, input int hold,
                          input longint eq, input longint er, input longint edz,
                          input longint eov);
    int n;
    int guard;
    logic [31:0] rv;
    @(negedge clk);
    ce = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    Y = WY'(y);
    C = WC'(c);
    chk("pre_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    guard = 0;
    while (!out_valid && guard < 200) begin
      if (tog) ce = ~ce;
      @(posedge clk);
      if (ce) n++;
      @(negedge clk);
      guard++;
    end
    chk("latency", longint'(n), (c == 0) ? 0 : WY);
    chk("lit_q", longint'(Q), eq);
    chk("lit_r", longint'(R), er);
    chk("lit_dz", longint'(dz), edz);
    chk("lit_ovf", longint'(ovf), eov);
    ce = 1'b1;
    if (hold > 0) begin
      in_valid = 1'b1;
      rv = $urandom;
      Y = rv[WY-1:0];
      C = 10'sd3;
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        chk("hold_in_ready", longint'(in_ready), 0);
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_q", longint'(Q), eq);
        chk("hold_r", longint'(R), er);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", longint'(in_ready), 1);
    chk("release_out_valid", longint'(out_valid), 0);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rv;
    int sel;
    int v;
    #12;
    chk("rst_q", longint'(Q), 0);
    chk("rst_r", longint'(R), 0);
    chk("rst_dz", longint'(dz), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", longint'(in_ready), 1);

    pin_model(35, 5, 7, 0, 0, 0);
    pin_model(-37, 5, -7, -2, 0, 0);
    pin_model(37, -5, -7, 2, 0, 0);
    pin_model(-1048576, -512, 1023, 0, 0, 1);
    pin_model(100, 0, 0, 0, 1, 0);
    pin_model(1048575, 1, 1023, 0, 0, 1);
    pin_model(-1048576, 1, -1024, 0, 0, 1);

    run_pair(35, 5, 1'b0, 0, 7, 0, 0, 0);
    run_pair(-37, 5, 1'b0, 0, -7, -2, 0, 0);
    run_pair(37, -5, 1'b0, 0, -7, 2, 0, 0);
    run_pair(-1048576, -512, 1'b0, 0, 1023, 0, 0, 1);
    run_pair(100, 0, 1'b0, 0, 0, 0, 1, 0);
    run_pair(1048575, 1, 1'b0, 0, 1023, 0, 0, 1);
    run_pair(-1048576, 1, 1'b0, 0, -1024, 0, 0, 1);
    run_pair(1000, -512, 1'b0, 0, -1, 488, 0, 0);
    run_pair(35, 5, 1'b1, 0, 7, 0, 0, 0);
    run_pair(35, 5, 1'b0, 10, 7, 0, 0, 0);

    // Abort a division partway through with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1;
    Y = 21'sd35;
    C = 10'sd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_in_ready", longint'(in_ready), 1);
    chk("abort_q", longint'(Q), 0);
    #1;
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_no_result", longint'(out_valid), 0);
    run_pair(-36, -6, 1'b0, 0, 6, 0, 0, 0);

    // Randomized traffic with random clock enable and back-pressure.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ce = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      sel = $urandom_range(0, 7);
      rv = $urandom;
      if (sel == 0) Y = {1'b1, {(WY-1){1'b0}}};
      else if (sel == 1) Y = {1'b0, {(WY-1){1'b1}}};
      else Y = rv[WY-1:0];
      sel = $urandom_range(0, 7);
      rv = $urandom;
      v = $urandom_range(0, 16) - 8;
      if (sel == 0) C = '0;
      else if (sel == 1) C = {1'b1, {(WC-1){1'b0}}};
      else if (sel == 2) C = 10'sd1;
      else if (sel == 3) C = -10'sd1;
      else if (sel == 4) C = v[WC-1:0];
      else C = rv[WC-1:0];
    end
    @(negedge clk);
    ce = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
